gray_sync_multi: RTL

GRAY_SYNC_MULTI -- requirements
Module: gray_sync_multi

---
 rtl/gray_sync_multi.sv | 109 ++++++++++
 1 files changed

// File: rtl/gray_sync_multi.sv
// Multi-channel gray-code pointer synchroniser with a shared INIT/LOAD/TRACK
// controller, per-channel step validation and sticky step errors.
module gray_sync_multi #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 1,
  parameter int STAGES   = 2,
  parameter int MAX_STEP = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] gray_in,
  input  logic [CHANNELS-1:0]       resync,
  input  logic [CHANNELS-1:0]       err_clr,
  output logic                      ready,
  output logic [CHANNELS*WIDTH-1:0] bin_out,
  output logic [CHANNELS-1:0]       updated,
  output logic [CHANNELS-1:0]       step_err
);
  localparam int TW = CHANNELS * WIDTH;
  localparam logic [WIDTH-1:0] MAX_D = WIDTH'(MAX_STEP);
  localparam logic [2:0] INIT_LAST = 3'(STAGES);

  typedef enum logic [1:0] {INIT, LOAD, TRACK} state_t;

  state_t        state;
  logic [2:0]    init_cnt;
  logic [TW-1:0] sync [STAGES];
  logic [TW-1:0] last;
  logic [TW-1:0] last_q;

  assign last = sync[STAGES-1];

  // Plain flop chain; last_q sits after the final stage for the one-bit-change check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= '{default: '0};
      last_q <= '0;
    end else begin
      sync[0] <= gray_in;
      for (int unsigned s = 1; s < STAGES; s++) sync[s] <= sync[s-1];
      last_q <= last;
    end
  end

  // INIT spans STAGES+1 cycles so the chain holds the post-reset input before LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      init_cnt <= '0;
      ready    <= 1'b0;
    end else begin
      unique case (state)
        INIT: begin
          if (init_cnt == INIT_LAST) state <= LOAD;
          else init_cnt <= init_cnt + 3'd1;
        end
        LOAD: begin
          state <= TRACK;
          ready <= 1'b1;
        end
        TRACK:   state <= TRACK;
        default: state <= INIT;
      endcase
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] g_now, g_prev, cand, delta, diff, bin_q;
    logic             multi, bad, err_set, upd_q, err_q;

    always_comb begin
      g_now  = last[c*WIDTH +: WIDTH];
      g_prev = last_q[c*WIDTH +: WIDTH];
      for (int unsigned i = 0; i < WIDTH; i++) cand[i] = ^(g_now >> i);
      diff    = g_now ^ g_prev;
      multi   = |(diff & (diff - WIDTH'(1)));
      delta   = cand - bin_q;
      bad     = multi || (delta > MAX_D);
      err_set = (state == TRACK) && !resync[c] && bad;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        bin_q <= '0;
        upd_q <= 1'b0;
        err_q <= 1'b0;
      end else begin
        upd_q <= 1'b0;
        if (state == LOAD) begin
          bin_q <= cand;
        end else if (state == TRACK) begin
          if (resync[c]) begin
            bin_q <= cand;
          end else if (!bad && delta != '0) begin
            bin_q <= cand;
            upd_q <= 1'b1;
          end
        end
        if (err_set) err_q <= 1'b1;
        else if (err_clr[c]) err_q <= 1'b0;
      end
    end

    assign bin_out[c*WIDTH +: WIDTH] = bin_q;
    assign updated[c]                = upd_q;
    assign step_err[c]               = err_q;
  end

endmodule
